// File: rtl/muldiv_iter_pkg.sv
// Shared constants, op encoding and FSM states for the iterative RV32M multiply/divide unit.
// The internal op encoding deliberately matches funct3 so decode is a plain cast.
package muldiv_iter_pkg;

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic opIsDiv(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic opIsRem(input md_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_dec.sv
// Combinational M-extension decode: op, operand signedness and is_muldiv.
// Divide ops (funct3 1xx) are only recognised when MULDIV_DIV_EN is defined.
module muldiv_dec
  import muldiv_iter_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       is_muldiv_o,
  output md_op_e     op_o,
  output logic       a_signed_o,
  output logic       b_signed_o
);

  always_comb begin
    op_o        = md_op_e'(funct3_i);
    is_muldiv_o = (opcode_i == OPC_ARI_RTYPE) && (funct7_i == FNC7_MULDIV);
`ifndef MULDIV_DIV_EN
    if (funct3_i[2]) is_muldiv_o = 1'b0;
`endif
    a_signed_o = 1'b0;
    b_signed_o = 1'b0;
    case (funct3_i)
      FNC_MUL, FNC_MULH, FNC_DIV, FNC_REM: begin
        a_signed_o = 1'b1;
        b_signed_o = 1'b1;
      end
      FNC_MULHSU: a_signed_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M multiply/divide unit with ready/valid handshake.
// Define MULDIV_DIV_EN to include the restoring divider and divide special cases.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             is_muldiv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  md_op_e            op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            dec_op;
  logic              a_signed, b_signed;
  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   fix_res;

`ifdef MULDIV_DIV_EN
  logic              rem_neg_q, rem_neg_d;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     rs_shift;
  logic              ge;
  logic [XLEN-1:0]   diff, rem_new;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, remv;
`endif

  muldiv_dec u_dec (
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .is_muldiv_o (is_muldiv),
    .op_o        (dec_op),
    .a_signed_o  (a_signed),
    .b_signed_o  (b_signed)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign out_tag   = tag_q;
  assign accept    = in_valid && in_ready && is_muldiv && !flush;

  // Operands are reduced to magnitudes up front; signs are reapplied in FIX.
  always_comb begin
    a_neg = a_signed & rs1[XLEN-1];
    b_neg = b_signed & rs2[XLEN-1];
    a_mag = a_neg ? -rs1 : rs1;
    b_mag = b_neg ? -rs2 : rs2;
  end

  // Shift-add step: the multiplier sits in the low half and drains out the bottom.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    mul_next = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    prod     = neg_q ? -acc_q : acc_q;
    mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  // Restoring step on {remainder, quotient}; a failed trial leaves the remainder as shifted.
  always_comb begin
    rs_shift = acc_q[2*XLEN-1:XLEN-1];
    ge       = (rs_shift >= {1'b0, b_q});
    diff     = rs_shift[XLEN-1:0] - b_q;
    rem_new  = ge ? diff : rs_shift[XLEN-1:0];
    div_next = {rem_new, acc_q[XLEN-2:0], ge};
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remv     = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res  = opIsDiv(op_q) ? (opIsRem(op_q) ? remv : quo) : mul_res;
  end

  always_comb begin
    div_by_zero = (rs2 == '0);
    div_ovf     = b_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special     = opIsDiv(dec_op) && (div_by_zero || div_ovf);
    if (opIsRem(dec_op)) special_res = div_by_zero ? rs1 : '0;
    else                 special_res = div_by_zero ? '1 : rs1;
  end
`else
  always_comb fix_res = mul_res;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = dec_op;
          tag_d   = in_tag;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          b_d     = b_mag;
          state_d = ST_CALC;
`ifdef MULDIV_DIV_EN
          rem_neg_d = a_neg;
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = opIsDiv(op_q) ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush kills whatever is in flight, including a result waiting in DONE.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk) begin
    if (reset) rem_neg_q <= 1'b0;
    else       rem_neg_q <= rem_neg_d;
  end
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter with a result/tag scoreboard.
// Divide cases are exercised only when MULDIV_DIV_EN is defined; otherwise divide rejection is checked.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             is_muldiv;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rs1       (rs1),
    .rs2       (rs2),
    .in_tag    (in_tag),
    .flush     (flush),
    .is_muldiv (is_muldiv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  // Reference model built on the simulator's 64-bit arithmetic.
  function automatic logic [31:0] modelResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic driveReq(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    opcode   = OPC_ARI_RTYPE;
    funct7   = FNC7_MULDIV;
    funct3   = f3;
    rs1      = a;
    rs2      = b;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Issues one request, waits for its result and checks latency, hold behaviour and scoreboard entry.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input int stall);
    int   cyc;
    exp_t e;
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, " idle"}, 64'(in_ready), 64'd1);
    out_ready = (stall == 0);
    driveReq(f3, a, b, tag);
    e.res = modelResult(f3, a, b);
    e.tag = tag;
    expQ.push_back(e);
    #1 checkOutput({name, " is_muldiv"}, 64'(is_muldiv), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, " latency"}, 64'(cyc), 64'(expLatency(f3, a, b)));
    checkOutput({name, " busy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({name, " hold valid"}, 64'(out_valid), 64'd1);
      checkOutput({name, " hold result"}, 64'(result), 64'(e.res));
      checkOutput({name, " hold tag"}, 64'(out_tag), 64'(e.tag));
      checkOutput({name, " hold busy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    if (expQ.size() == 0) begin
      checkOutput({name, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({name, " result"}, 64'(result), 64'(e.res));
      checkOutput({name, " tag"}, 64'(out_tag), 64'(e.tag));
    end
    @(negedge clk);
    checkOutput({name, " ready after"}, 64'(in_ready), 64'd1);
    checkOutput({name, " valid after"}, 64'(out_valid), 64'd0);
  endtask

  // Starts a multiply, then kills it after a few CALC cycles with flush or reset.
  task automatic abortTest(input string name, input bit useReset);
    bit seen;
    @(negedge clk);
    out_ready = 1'b1;
    driveReq(FNC_MUL, 32'd1234, 32'd5678, 5'd9);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput({name, " busy"}, 64'(in_ready), 64'd0);
    if (useReset) reset = 1'b1;
    else          flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    checkOutput({name, " ready"}, 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput({name, " no valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    reset     = 1'b1;
    in_valid  = 1'b0;
    opcode    = '0;
    funct3    = '0;
    funct7    = '0;
    rs1       = '0;
    rs2       = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;

    opcode = OPC_ARI_RTYPE;
    funct7 = 7'b0000000;
    funct3 = FNC_MUL;
    #1 checkOutput("decode plain add", 64'(is_muldiv), 64'd0);

    applyStimulus("mul 7x-3", FNC_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
    applyStimulus("mulhu", FNC_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    applyStimulus("mulh", FNC_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
    applyStimulus("mulhsu", FNC_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
    applyStimulus("mul stall", FNC_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 5);

`ifdef MULDIV_DIV_EN
    applyStimulus("div -20/3", FNC_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 0);
    applyStimulus("rem -20/3", FNC_REM, 32'hFFFF_FFEC, 32'd3, 5'd8, 0);
    applyStimulus("divu 20/3", FNC_DIVU, 32'd20, 32'd3, 5'd9, 0);
    applyStimulus("div 5/0", FNC_DIV, 32'd5, 32'd0, 5'd10, 0);
    applyStimulus("remu 5/0", FNC_REMU, 32'd5, 32'd0, 5'd11, 0);
    applyStimulus("div ovf", FNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    applyStimulus("rem ovf", FNC_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    applyStimulus("div stall", FNC_DIV, 32'd5, 32'd0, 5'd14, 3);
`else
    @(negedge clk);
    driveReq(FNC_DIV, 32'd20, 32'd3, 5'd7);
    #1 checkOutput("nodiv is_muldiv", 64'(is_muldiv), 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("nodiv in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("nodiv out_valid", 64'(out_valid), 64'd0);
`endif

    abortTest("flush", 1'b0);
    abortTest("midreset", 1'b1);

    @(negedge clk);
    driveReq(FNC_MUL, 32'd3, 32'd4, 5'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush+valid ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("flush+valid no valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 6; i++) begin
`ifdef MULDIV_DIV_EN
      f3 = 3'($urandom_range(0, 7));
`else
      f3 = 3'($urandom_range(0, 3));
`endif
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      applyStimulus("random", f3, a, b, 5'($urandom_range(0, 31)), i % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
